inst_fetch_ctrl: RTL and testbench

Fetch sequencer that sits between the PC/branch logic, the ICache and the `Instbuffer` instruction FIFO. It generates ICache read requests, keeps at most one request outstanding, and converts each response into one or two FIFO pushes. It throttles on the buffer's full flag and redirects on exception flush or branch resolution. When a branch's delay slot has not yet been fetched, it re-fetches that delay slot alone before the branch target.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_gen.sv | 60 ++++++
 rtl/inst_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch sequencer.
package fetch_pkg;

   // Widths match InstBus / InstAddrBus of the rest of the core
   localparam int unsigned InstBusW     = 32;
   localparam int unsigned InstAddrBusW = 32;

   localparam logic [InstAddrBusW-1:0] DefaultResetPc = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait
   } fetch_state_e;

   // ICache addresses are word aligned; drop the byte offset
   function automatic logic [InstAddrBusW-1:0] word_align(input logic [InstAddrBusW-1:0] a);
      return a & ~(InstAddrBusW'(3));
   endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch pc register, next-pc selection and delay-slot re-fetch mode.
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter logic [InstAddrBusW-1:0] RESET_PC = DefaultResetPc
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_flush,
   input  logic [InstAddrBusW-1:0] i_flush_pc,
   input  logic                    i_br_redirect,
   input  logic [InstAddrBusW-1:0] i_br_target,
   input  logic [InstAddrBusW-1:0] i_br_ds_pc,
   input  logic                    i_br_ds_pending,
   input  logic                    i_advance,
   output logic [InstAddrBusW-1:0] o_pc,
   output logic                    o_ds_mode
);

   logic [InstAddrBusW-1:0] r_pc;
   logic [InstAddrBusW-1:0] r_ds_target;
   logic                    r_ds_mode;
   logic [InstAddrBusW-1:0] w_seq_pc;

   // A pc in the upper half of an 8-byte block only gets one word per fetch
   assign w_seq_pc = r_pc[2] ? (r_pc + InstAddrBusW'(4)) : (r_pc + InstAddrBusW'(8));

   // pc update: flush beats redirect beats sequential advance after a push
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_ds_target <= '0;
         r_ds_mode   <= 1'b0;
      end else if (i_flush) begin
         r_pc      <= word_align(i_flush_pc);
         r_ds_mode <= 1'b0;
      end else if (i_br_redirect) begin
         if (i_br_ds_pending) begin
            // Fetch the delay slot alone first, then jump to the saved target
            r_pc        <= word_align(i_br_ds_pc);
            r_ds_target <= word_align(i_br_target);
            r_ds_mode   <= 1'b1;
         end else begin
            r_pc      <= word_align(i_br_target);
            r_ds_mode <= 1'b0;
         end
      end else if (i_advance) begin
         if (r_ds_mode) begin
            r_pc      <= r_ds_target;
            r_ds_mode <= 1'b0;
         end else begin
            r_pc <= w_seq_pc;
         end
      end
   end

   assign o_pc      = r_pc;
   assign o_ds_mode = r_ds_mode;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: ICache fetch sequencer feeding the Instbuffer, one request in flight.
// Build option: define IFETCH_PERF_CNT_EN to include the fetch / buffer-full counters.
module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [InstAddrBusW-1:0] RESET_PC = DefaultResetPc,
   parameter int unsigned             CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic [InstAddrBusW-1:0] flush_pc_i,
   input  logic                    br_redirect_i,
   input  logic [InstAddrBusW-1:0] br_target_i,
   input  logic [InstAddrBusW-1:0] br_ds_pc_i,
   input  logic                    br_ds_pending_i,
   input  logic                    buffer_full_i,
   output logic                    icache_req_o,
   output logic [InstAddrBusW-1:0] icache_addr_o,
   input  logic                    icache_ack_i,
   input  logic                    icache_rvalid_i,
   input  logic [InstBusW-1:0]     icache_rdata1_i,
   input  logic [InstBusW-1:0]     icache_rdata2_i,
   output logic [InstBusW-1:0]     inst1_o,
   output logic [InstBusW-1:0]     inst2_o,
   output logic [InstAddrBusW-1:0] inst1_addr_o,
   output logic [InstAddrBusW-1:0] inst2_addr_o,
   output logic                    inst1_valid_o,
   output logic                    inst2_valid_o,
   output logic                    only_delayslot_o,
   output logic [CNT_W-1:0]        perf_fetch_cnt_o,
   output logic [CNT_W-1:0]        perf_full_cnt_o
);

   fetch_state_e            r_state;
   logic                    r_drop;
   logic [InstBusW-1:0]     r_inst1;
   logic [InstBusW-1:0]     r_inst2;
   logic [InstAddrBusW-1:0] r_inst1_addr;
   logic [InstAddrBusW-1:0] r_inst2_addr;
   logic                    r_inst1_valid;
   logic                    r_inst2_valid;
   logic                    r_only_ds;

   logic [InstAddrBusW-1:0] w_pc;
   logic                    w_ds_mode;
   logic                    w_redir;
   logic                    w_req;
   logic                    w_accept;
   logic                    w_resp;
   logic                    w_push;

   assign w_redir  = flush_i | br_redirect_i;
   assign w_req    = (r_state == StReq) && !buffer_full_i;
   assign w_accept = w_req && icache_ack_i;
   assign w_resp   = (r_state == StWait) && icache_rvalid_i;
   // A redirect in the response cycle consumes that response, so no drop is left pending
   assign w_push   = w_resp && !r_drop && !w_redir;

   fetch_pc_gen #(
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk             (clk),
      .rst             (rst),
      .i_flush         (flush_i),
      .i_flush_pc      (flush_pc_i),
      .i_br_redirect   (br_redirect_i),
      .i_br_target     (br_target_i),
      .i_br_ds_pc      (br_ds_pc_i),
      .i_br_ds_pending (br_ds_pending_i),
      .i_advance       (w_push),
      .o_pc            (w_pc),
      .o_ds_mode       (w_ds_mode)
   );

   // Request/response sequencing, drop tracking and the registered push outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StIdle;
         r_drop        <= 1'b0;
         r_inst1       <= '0;
         r_inst2       <= '0;
         r_inst1_addr  <= '0;
         r_inst2_addr  <= '0;
         r_inst1_valid <= 1'b0;
         r_inst2_valid <= 1'b0;
         r_only_ds     <= 1'b0;
      end else begin
         r_inst1_valid <= 1'b0;
         r_inst2_valid <= 1'b0;
         r_only_ds     <= 1'b0;
         case (r_state)
            StIdle: r_state <= StReq;
            StReq: begin
               if (w_accept) begin
                  r_state <= StWait;
                  // The accepted request already targets the stale pc
                  if (w_redir) r_drop <= 1'b1;
               end
            end
            StWait: begin
               if (w_resp) begin
                  r_state <= StReq;
                  r_drop  <= 1'b0;
                  if (w_push) begin
                     r_inst1       <= icache_rdata1_i;
                     r_inst2       <= icache_rdata2_i;
                     r_inst1_addr  <= w_pc;
                     r_inst2_addr  <= w_pc + InstAddrBusW'(4);
                     r_inst1_valid <= 1'b1;
                     r_inst2_valid <= !w_pc[2] && !w_ds_mode;
                     r_only_ds     <= w_ds_mode;
                  end
               end else if (w_redir) begin
                  r_drop <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign icache_req_o     = w_req;
   assign icache_addr_o    = word_align(w_pc);
   assign inst1_o          = r_inst1;
   assign inst2_o          = r_inst2;
   assign inst1_addr_o     = r_inst1_addr;
   assign inst2_addr_o     = r_inst2_addr;
   assign inst1_valid_o    = r_inst1_valid;
   assign inst2_valid_o    = r_inst2_valid;
   assign only_delayslot_o = r_only_ds;

`ifdef IFETCH_PERF_CNT_EN
   logic [CNT_W-1:0] r_fetch_cnt;
   logic [CNT_W-1:0] r_full_cnt;

   // Instructions delivered and REQ cycles stalled on a full buffer; both wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_cnt <= '0;
         r_full_cnt  <= '0;
      end else begin
         r_fetch_cnt <= r_fetch_cnt + CNT_W'(r_inst1_valid) + CNT_W'(r_inst2_valid);
         if ((r_state == StReq) && buffer_full_i) r_full_cnt <= r_full_cnt + CNT_W'(1);
      end
   end

   assign perf_fetch_cnt_o = r_fetch_cnt;
   assign perf_full_cnt_o  = r_full_cnt;
`else
   assign perf_fetch_cnt_o = '0;
   assign perf_full_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed test-plan sequences plus randomized traffic, checked against
// a transaction-level model of the fetch stream seen from the ICache side.
module tb_inst_fetch_ctrl;

   localparam logic [31:0] RstPc = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        br_redirect_i;
   logic [31:0] br_target_i;
   logic [31:0] br_ds_pc_i;
   logic        br_ds_pending_i;
   logic        buffer_full_i;
   logic        icache_req_o;
   logic [31:0] icache_addr_o;
   logic        icache_ack_i;
   logic        icache_rvalid_i;
   logic [31:0] icache_rdata1_i;
   logic [31:0] icache_rdata2_i;
   logic [31:0] inst1_o;
   logic [31:0] inst2_o;
   logic [31:0] inst1_addr_o;
   logic [31:0] inst2_addr_o;
   logic        inst1_valid_o;
   logic        inst2_valid_o;
   logic        only_delayslot_o;
   logic [31:0] perf_fetch_cnt_o;
   logic [31:0] perf_full_cnt_o;

   always #5 clk = ~clk;

   inst_fetch_ctrl #(
      .RESET_PC (RstPc),
      .CNT_W    (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .flush_i          (flush_i),
      .flush_pc_i       (flush_pc_i),
      .br_redirect_i    (br_redirect_i),
      .br_target_i      (br_target_i),
      .br_ds_pc_i       (br_ds_pc_i),
      .br_ds_pending_i  (br_ds_pending_i),
      .buffer_full_i    (buffer_full_i),
      .icache_req_o     (icache_req_o),
      .icache_addr_o    (icache_addr_o),
      .icache_ack_i     (icache_ack_i),
      .icache_rvalid_i  (icache_rvalid_i),
      .icache_rdata1_i  (icache_rdata1_i),
      .icache_rdata2_i  (icache_rdata2_i),
      .inst1_o          (inst1_o),
      .inst2_o          (inst2_o),
      .inst1_addr_o     (inst1_addr_o),
      .inst2_addr_o     (inst2_addr_o),
      .inst1_valid_o    (inst1_valid_o),
      .inst2_valid_o    (inst2_valid_o),
      .only_delayslot_o (only_delayslot_o),
      .perf_fetch_cnt_o (perf_fetch_cnt_o),
      .perf_full_cnt_o  (perf_full_cnt_o)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ICache contents: a distinct word per address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Model: next fetch address, the one outstanding request, and the push due next cycle
   logic [31:0] m_pc;
   logic [31:0] m_req_addr;
   logic [31:0] m_ds_target;
   bit          m_ds_mode;
   bit          m_started;
   bit          m_out;
   bit          m_discard;
   bit          e_valid1;
   bit          e_valid2;
   bit          e_only;
   logic [31:0] e_addr;
   logic [31:0] m_fetch_cnt;
   logic [31:0] m_full_cnt;

   // One clock cycle, entered and left at a falling edge
   task automatic step(input bit full, input bit fl, input logic [31:0] fl_pc, input bit br,
                       input bit pend, input logic [31:0] tgt, input logic [31:0] ds,
                       input bit ack_en, input bit rv_en);
      bit req_exp;
      bit acc;
      bit rv;
      bit push;
      req_exp         = m_started && !m_out && !full;
      acc             = req_exp && ack_en;
      rv              = m_out && rv_en;
      buffer_full_i   = full;
      flush_i         = fl;
      flush_pc_i      = fl_pc;
      br_redirect_i   = br;
      br_ds_pending_i = pend;
      br_target_i     = tgt;
      br_ds_pc_i      = ds;
      icache_ack_i    = acc;
      icache_rvalid_i = rv;
      icache_rdata1_i = rv ? mem_word(m_req_addr) : 32'hDEAD_BEEF;
      icache_rdata2_i = rv ? mem_word(m_req_addr + 32'd4) : 32'hDEAD_BEEF;
      #1;
      check_val("req", icache_req_o, req_exp);
      if (req_exp) check_val("addr", icache_addr_o, m_pc);
      check_val("valid1", inst1_valid_o, e_valid1);
      check_val("valid2", inst2_valid_o, e_valid2);
      check_val("only_ds", only_delayslot_o, e_only);
      if (e_valid1) begin
         check_val("addr1", inst1_addr_o, e_addr);
         check_val("inst1", inst1_o, mem_word(e_addr));
      end
      if (e_valid2) begin
         check_val("addr2", inst2_addr_o, e_addr + 32'd4);
         check_val("inst2", inst2_o, mem_word(e_addr + 32'd4));
      end
`ifdef IFETCH_PERF_CNT_EN
      check_val("fetch_cnt", perf_fetch_cnt_o, m_fetch_cnt);
      check_val("full_cnt", perf_full_cnt_o, m_full_cnt);
`else
      check_val("fetch_cnt", perf_fetch_cnt_o, 32'd0);
      check_val("full_cnt", perf_full_cnt_o, 32'd0);
`endif
      if (e_valid1) m_fetch_cnt += e_valid2 ? 32'd2 : 32'd1;
      if (m_started && !m_out && full) m_full_cnt += 32'd1;
      push = 1'b0;
      if (rv) begin
         m_out = 1'b0;
         if (!m_discard && !fl && !br) begin
            push     = 1'b1;
            e_addr   = m_req_addr;
            e_valid2 = !m_req_addr[2] && !m_ds_mode;
            e_only   = m_ds_mode;
            if (m_ds_mode) begin
               m_pc      = m_ds_target;
               m_ds_mode = 1'b0;
            end else begin
               m_pc = m_req_addr + (m_req_addr[2] ? 32'd4 : 32'd8);
            end
         end
         m_discard = 1'b0;
      end else if (m_out && (fl || br)) begin
         m_discard = 1'b1;
      end
      if (acc) begin
         m_out      = 1'b1;
         m_req_addr = m_pc;
         m_discard  = fl || br;
      end
      e_valid1 = push;
      if (!push) begin
         e_valid2 = 1'b0;
         e_only   = 1'b0;
      end
      if (fl) begin
         m_pc      = fl_pc & ~32'd3;
         m_ds_mode = 1'b0;
      end else if (br) begin
         if (pend) begin
            m_pc        = ds & ~32'd3;
            m_ds_target = tgt & ~32'd3;
            m_ds_mode   = 1'b1;
         end else begin
            m_pc      = tgt & ~32'd3;
            m_ds_mode = 1'b0;
         end
      end
      m_started = 1'b1;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1);
   endtask

   // Let any outstanding response return without issuing a new request
   task automatic drain();
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      rst = 1'b1;
      {flush_i, br_redirect_i, br_ds_pending_i, buffer_full_i} = '0;
      {icache_ack_i, icache_rvalid_i} = '0;
      flush_pc_i = '0; br_target_i = '0; br_ds_pc_i = '0;
      icache_rdata1_i = '0; icache_rdata2_i = '0;
      m_pc = RstPc; m_req_addr = '0; m_ds_target = '0; e_addr = '0;
      {m_ds_mode, m_started, m_out, m_discard, e_valid1, e_valid2, e_only} = '0;
      m_fetch_cnt = '0; m_full_cnt = '0;
      repeat (3) @(negedge clk);
      check_val("rst_req", icache_req_o, 1'b0);
      check_val("rst_addr", icache_addr_o, RstPc);
      check_val("rst_v1", inst1_valid_o, 1'b0);
      check_val("rst_v2", inst2_valid_o, 1'b0);
      check_val("rst_inst1", inst1_o, 32'd0);
      check_val("rst_addr2", inst2_addr_o, 32'd0);
      check_val("rst_only", only_delayslot_o, 1'b0);
      check_val("rst_fcnt", perf_fetch_cnt_o, 32'd0);
      rst = 1'b0;

      // Sequential fetch from reset with an immediate-ack ICache
      run(10);
      // Flush into the upper half of a block: single push, then pc+4
      step(0, 1, 32'h8000_0184, 0, 0, 0, 0, 0, 1);
      run(8);
      // Ten REQ cycles blocked by a full buffer
      drain();
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 1);
      run(6);
      // Flush while the request is in flight
      drain();
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 1, 32'h8000_0400, 0, 0, 0, 0, 0, 0);
      run(8);
      // Redirect with the delay slot still to fetch
      drain();
      step(0, 0, 0, 1, 1, 32'h8000_2000, 32'h8000_1004, 0, 1);
      run(10);
      // Flush and redirect together: flush wins
      step(0, 1, 32'h8000_3000, 1, 0, 32'h8000_5000, 0, 1, 1);
      run(8);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0, $urandom,
              $urandom_range(0, 20) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      run(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
